// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide datapath: operation
// encoding, sequencer FSM states and the default operand width.
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    // Multiply group encoding as presented by the execute stage.
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    // Sequencer states of mul_unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/mul.sv
// Unsigned iterative multiply core. One partial product is accumulated per
// clock while req_i is high; ready_o rises after XLEN such edges and the full
// 2*XLEN product is then available on p_o. Dropping req_i for a cycle clears
// the core, which is how the wrapper flushes it between operations.
module mul #(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                ready_o,
    output logic [2*XLEN-1:0]   p_o
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int IW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_MAX = CW'(XLEN);

    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] partial;
    logic [IW-1:0]     idx;

    // Partial product for the multiplier bit selected by the step counter.
    always_comb begin
        idx     = cnt[IW-1:0];
        partial = '0;
        if (b_i[idx]) begin
            partial = {{XLEN{1'b0}}, a_i} << idx;
        end
    end

    // Accumulate while requested; hold once finished; clear when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
            acc <= '0;
        end else if (!req_i) begin
            cnt <= '0;
            acc <= '0;
        end else if (cnt != CNT_MAX) begin
            acc <= acc + partial;
            cnt <= cnt + 1'b1;
        end
    end

    assign ready_o = (cnt == CNT_MAX);
    assign p_o     = acc;

endmodule

// File: rtl/mul_unit.sv
// Sequencing wrapper for the RV32M multiply group. Accepts one operation over
// valid/ready, feeds operand magnitudes to the unsigned core, sign-corrects
// and half-selects the product, and holds the result until consumed.
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// and the receiver's ready are both high; valid, once raised, stays high with
// stable payload until that edge (unless kill_i abandons the operation).
module mul_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [1:0]        op_i,
    input  logic [XLEN-1:0]   rs1_i,
    input  logic [XLEN-1:0]   rs2_i,
    input  logic              kill_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic              busy_o,
    output mul_state_e        state_o
);

    mul_state_e        state, state_d;
    mul_op_e           op_in, op_q;
    logic [XLEN-1:0]   a_q, b_q, a_mag, b_mag;
    logic              neg_q, neg_d, sign1, sign2;
    logic              accept, core_req, core_done;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   sel;

    // Operand sign handling: MUL is sign-agnostic in its low half, so only
    // MULH/MULHSU treat rs1 as signed and only MULH treats rs2 as signed.
    always_comb begin
        op_in = mul_op_e'(op_i);
        sign1 = rs1_i[XLEN-1] & ((op_in == OP_MULH) || (op_in == OP_MULHSU));
        sign2 = rs2_i[XLEN-1] & (op_in == OP_MULH);
        a_mag = sign1 ? (-rs1_i) : rs1_i;
        b_mag = sign2 ? (-rs2_i) : rs2_i;
        neg_d = sign1 ^ sign2;
    end

    // Negate the unsigned product when exactly one operand was negative, then
    // pick the half the instruction asks for.
    always_comb begin
        prod_fix = neg_q ? (-prod) : prod;
        sel      = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end

    assign accept   = (state == ST_IDLE) && valid_i && !kill_i;
    assign core_req = (state == ST_RUN);

    mul #(.XLEN(XLEN)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (~rst_ni),
        .req_i   (core_req),
        .a_i     (a_q),
        .b_i     (b_q),
        .ready_o (core_done),
        .p_o     (prod)
    );

    // Next-state logic; kill_i overrides both core completion and ready_i.
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN: begin
                if (kill_i)         state_d = ST_IDLE;
                else if (core_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (kill_i)       state_d = ST_IDLE;
                else if (ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_d;
    end

    // Operand latch on accept and result capture on core completion.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            result_o <= '0;
        end else begin
            if (accept) begin
                op_q  <= op_in;
                a_q   <= a_mag;
                b_q   <= b_mag;
                neg_q <= neg_d;
            end
            if ((state == ST_RUN) && core_done && !kill_i) begin
                result_o <= sel;
            end
        end
    end

    assign ready_o = (state == ST_IDLE);
    assign valid_o = (state == ST_DONE);
    assign busy_o  = (state != ST_IDLE);
    assign state_o = state;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed RV32M multiply cases, random
// operations, backpressure, kill in RUN/DONE and asynchronous reset mid-RUN.
module tb_mul_unit;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_o;
    logic [1:0]        op_i = 2'b00;
    logic [XLEN-1:0]   rs1_i = '0;
    logic [XLEN-1:0]   rs2_i = '0;
    logic              kill_i = 1'b0;
    logic              valid_o;
    logic              ready_i = 1'b0;
    logic [XLEN-1:0]   result_o;
    logic              busy_o;
    mul_state_e        state_o;

    logic [XLEN-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    mul_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .kill_i   (kill_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .busy_o   (busy_o),
        .state_o  (state_o)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    // Reference model: sign-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] ea, eb, p;
        ea = (op == 2'b01 || op == 2'b10) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
        eb = (op == 2'b01) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver: called at a negedge; offers the op, accept happens on the next posedge.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        chk("issue_ready", {63'd0, ready_o}, 64'd1);
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        valid_i = 1'b1;
        @(posedge clk_i);
        exp_q.push_back(exp);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Counts edges from the accept edge until valid_o, then scores the result.
    task automatic wait_result(input string tag);
        int n;
        logic [XLEN-1:0] e;
        n = 0;
        while (n < 100) begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
            if (valid_o) break;
        end
        chk({tag, "_lat"}, 64'(n), 64'(LAT));
        chk({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk(tag, {32'd0, result_o}, {32'd0, e});
        end
    endtask

    task automatic consume(input string tag);
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        chk({tag, "_idle_valid"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_idle_ready"}, {63'd0, ready_o}, 64'd1);
    endtask

    initial begin
        logic [XLEN-1:0] held;
        logic seen;
        logic [1:0] rop;
        logic [XLEN-1:0] ra, rb;

        // Reset
        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_result", {32'd0, result_o}, 64'd0);
        chk("rst_state", {62'd0, state_o}, {62'd0, ST_IDLE});
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Directed cases
        issue(2'b00, 32'd7, 32'd6, 32'h0000_002A);                 wait_result("mul_7x6");          consume("c1");
        issue(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);         wait_result("mul_m1x2");         consume("c2");
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000); wait_result("mulh_min_min");     consume("c3");
        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000); wait_result("mulh_m1_m1");       consume("c4");
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);         wait_result("mulh_m1_1");        consume("c5");
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_result("mulhsu_m1_max");    consume("c6");
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_result("mulhu_max_max");    consume("c7");

        // Backpressure in DONE
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_result("bp_op");
        held = result_o;
        repeat (10) begin
            @(negedge clk_i);
            chk("bp_valid", {63'd0, valid_o}, 64'd1);
            chk("bp_result", {32'd0, result_o}, {32'd0, held});
            chk("bp_ready", {63'd0, ready_o}, 64'd0);
        end
        consume("bp");
        issue(2'b00, 32'd3, 32'd5, 32'd15); wait_result("bp_next"); consume("c8");

        // Kill in RUN cycle 10
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1000, 32'h0000_0DEA);
        repeat (9) @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b0;
        chk("kill_run_busy", {63'd0, busy_o}, 64'd0);
        chk("kill_run_ready", {63'd0, ready_o}, 64'd1);
        void'(exp_q.pop_back());
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) seen = 1'b1;
        end
        chk("kill_run_no_valid", {63'd0, seen}, 64'd0);
        issue(2'b10, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF); wait_result("after_kill"); consume("c9");

        // Kill in DONE together with ready_i while a new op is offered
        issue(2'b00, 32'd100, 32'd100, 32'd10000);
        wait_result("kill_done_op");
        op_i = 2'b00; rs1_i = 32'd1; rs2_i = 32'd1;
        kill_i = 1'b1; ready_i = 1'b1; valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b0; ready_i = 1'b0; valid_i = 1'b0;
        chk("kill_done_busy", {63'd0, busy_o}, 64'd0);
        chk("kill_done_valid", {63'd0, valid_o}, 64'd0);
        repeat (2) @(negedge clk_i);
        chk("kill_done_no_accept", {63'd0, busy_o}, 64'd0);

        // Asynchronous reset mid-RUN
        issue(2'b01, 32'h8000_0000, 32'd7, 32'hFFFF_FFFC);
        repeat (5) @(negedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_ready", {63'd0, ready_o}, 64'd1);
        chk("arst_valid", {63'd0, valid_o}, 64'd0);
        chk("arst_busy", {63'd0, busy_o}, 64'd0);
        chk("arst_result", {32'd0, result_o}, 64'd0);
        exp_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        issue(2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001); wait_result("post_rst"); consume("c10");

        // Random operations scored against the model
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            issue(rop, ra, rb, model(rop, ra, rb));
            wait_result("rand");
            consume("cr");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
